// File: rtl/sub_seq_ctrl_pkg.sv
// Shared definitions for the nibble-serial subtractor.
// Reversible gate cells are modelled as functions; only the non-passthrough
// outputs are returned.
package sub_seq_ctrl_pkg;

  localparam int unsigned SLICE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Feynman (CNOT) cell: Q = A ^ B
  function automatic logic feynman(input logic a, input logic b);
    return a ^ b;
  endfunction

  // Peres cell: {Q, R} = {A ^ B, (A & B) ^ C}
  function automatic logic [1:0] peres(input logic a, input logic b, input logic c);
    return {a ^ b, (a & b) ^ c};
  endfunction

endpackage

// File: rtl/sub_nibble_slice.sv
// 4-bit a - b - bin slice built as a + ~b + ~bin from Feynman inverters and
// Peres-pair full adders; bout is the inverted final carry.
module sub_nibble_slice
  import sub_seq_ctrl_pkg::*;
(
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  input  logic               bin,
  output logic [SLICE_W-1:0] diff,
  output logic               bout
);

  logic [SLICE_W:0] c;
  logic [1:0]       p1;
  logic [1:0]       p2;
  logic             nb;

  // ripple through the four gate-level full adders
  always_comb begin
    c    = '0;
    diff = '0;
    p1   = '0;
    p2   = '0;
    nb   = 1'b0;
    c[0] = feynman(bin, 1'b1);
    for (int unsigned i = 0; i < SLICE_W; i++) begin
      nb        = feynman(b[i], 1'b1);
      p1        = peres(a[i], nb, 1'b0);
      p2        = peres(p1[1], c[i], p1[0]);
      diff[i]   = p2[1];
      c[i+1]    = p2[0];
    end
    bout = feynman(c[SLICE_W], 1'b1);
  end

endmodule

// File: rtl/sub_seq_ctrl.sv
// Nibble-serial two's-complement subtractor, one 4-bit slice per cycle.
// Optional: define SUB_SEQ_SAT_EN to saturate out_diff on signed overflow.
module sub_seq_ctrl
  import sub_seq_ctrl_pkg::*;
#(
  parameter int unsigned NIBBLES = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [SLICE_W*NIBBLES-1:0]   in_a,
  input  logic [SLICE_W*NIBBLES-1:0]   in_b,
  input  logic                         flush,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [SLICE_W*NIBBLES-1:0]   out_diff,
  output logic                         out_borrow,
  output logic                         out_zero,
  output logic                         out_parity,
  output logic                         out_sign,
  output logic                         out_overflow,
  output logic                         busy
);

  localparam int unsigned W     = SLICE_W * NIBBLES;
  localparam int unsigned IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  state_t             state, state_n;
  logic [W-1:0]       a_q, b_q, diff_q, res;
  logic [IDX_W-1:0]   idx;
  logic               borrow;
  logic [SLICE_W-1:0] a_nib, b_nib, d_nib;
  logic               bout;
  logic               accept, last, ovf;

  assign accept = (state == IDLE) && in_valid && !flush;
  assign last   = (idx == IDX_W'(NIBBLES - 1));
  assign a_nib  = a_q[idx*SLICE_W +: SLICE_W];
  assign b_nib  = b_q[idx*SLICE_W +: SLICE_W];

  sub_nibble_slice u_slice (
    .a    (a_nib),
    .b    (b_nib),
    .bin  (borrow),
    .diff (d_nib),
    .bout (bout)
  );

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  // next-state: flush wins over everything, including a new offer
  always_comb begin
    state_n = state;
    if (flush) begin
      state_n = IDLE;
    end else begin
      unique case (state)
        IDLE:    if (in_valid) state_n = RUN;
        RUN:     if (last)     state_n = DONE;
        DONE:    if (out_ready) state_n = IDLE;
        default: state_n = IDLE;
      endcase
    end
  end

  // operand capture and per-cycle slice accumulation
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q    <= '0;
      b_q    <= '0;
      diff_q <= '0;
      idx    <= '0;
      borrow <= 1'b0;
    end else if (accept) begin
      a_q    <= in_a;
      b_q    <= in_b;
      diff_q <= '0;
      idx    <= '0;
      borrow <= 1'b0;
    end else if (state == RUN && !flush) begin
      diff_q[idx*SLICE_W +: SLICE_W] <= d_nib;
      borrow                         <= bout;
      idx                            <= last ? '0 : idx + 1'b1;
    end
  end

  // result/flag formation from the full-width difference; all zero outside DONE
  always_comb begin
    ovf = (a_q[W-1] ^ b_q[W-1]) & (a_q[W-1] ^ diff_q[W-1]);
    res = diff_q;
`ifdef SUB_SEQ_SAT_EN
    if (ovf) res = a_q[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
`endif
    in_ready     = (state == IDLE);
    busy         = (state != IDLE);
    out_valid    = (state == DONE);
    out_diff     = '0;
    out_borrow   = 1'b0;
    out_zero     = 1'b0;
    out_parity   = 1'b0;
    out_sign     = 1'b0;
    out_overflow = 1'b0;
    if (state == DONE) begin
      out_diff     = res;
      out_borrow   = borrow;
      out_zero     = (res == '0);
      out_parity   = ^res;
      out_sign     = res[W-1];
      out_overflow = ovf;
    end
  end

endmodule

// File: tb/tb_sub_seq_ctrl.sv
// Scoreboard bench for sub_seq_ctrl (NIBBLES=4); honours SUB_SEQ_SAT_EN.
module tb_sub_seq_ctrl;

  localparam int unsigned NIB = 4;
  localparam int unsigned W   = 4 * NIB;

  typedef struct packed {
    logic [W-1:0] diff;
    logic         borrow;
    logic         zero;
    logic         parity;
    logic         sign;
    logic         ovf;
  } res_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid, in_ready, flush, out_valid, out_ready, busy;
  logic [W-1:0] in_a, in_b, out_diff;
  logic         out_borrow, out_zero, out_parity, out_sign, out_overflow;

  res_t sb[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  sub_seq_ctrl #(.NIBBLES(NIB)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_a         (in_a),
    .in_b         (in_b),
    .flush        (flush),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_diff     (out_diff),
    .out_borrow   (out_borrow),
    .out_zero     (out_zero),
    .out_parity   (out_parity),
    .out_sign     (out_sign),
    .out_overflow (out_overflow),
    .busy         (busy)
  );

  function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b);
    res_t         r;
    logic [W:0]   full;
    logic [W-1:0] d;
    full     = {1'b0, a} - {1'b0, b};
    d        = full[W-1:0];
    r.borrow = full[W];
    r.ovf    = (a[W-1] != b[W-1]) && (d[W-1] != a[W-1]);
`ifdef SUB_SEQ_SAT_EN
    if (r.ovf) d = a[W-1] ? 16'h8000 : 16'h7FFF;
`endif
    r.diff   = d;
    r.zero   = (d == '0);
    r.parity = ^d;
    r.sign   = d[W-1];
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // one transaction: offer, time the latency, hold off out_ready, then handshake
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input int hold, input bit keep_valid);
    int   n;
    res_t exp, got;
    n = 0;
    while (!in_ready && n < 50) begin tick(); n++; end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL accept_wait in_ready=%b required 1", in_ready);
      return;
    end
    in_a = a; in_b = b; in_valid = 1'b1;
    tick();
    sb.push_back(model(a, b));
    if (keep_valid) begin
      in_a = ~a; in_b = a ^ 16'h5A5A;
    end else begin
      in_valid = 1'b0;
    end
    n = 0;
    while (!out_valid && n < 20) begin tick(); n++; end
    checks++;
    if (n !== NIB || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL latency a=%h b=%h cycles=%0d required %0d", a, b, n, NIB);
    end
    exp = sb.pop_front();
    for (int h = 0; h <= hold; h++) begin
      got = {out_diff, out_borrow, out_zero, out_parity, out_sign, out_overflow};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL result a=%h b=%h hold=%0d got diff=%h b/z/p/s/o=%b%b%b%b%b required diff=%h b/z/p/s/o=%b%b%b%b%b",
                 a, b, h, got.diff, got.borrow, got.zero, got.parity, got.sign, got.ovf,
                 exp.diff, exp.borrow, exp.zero, exp.parity, exp.sign, exp.ovf);
      end
      checks++;
      if (in_ready !== 1'b0 || busy !== 1'b1 || out_valid !== 1'b1) begin
        errors++;
        $display("FAIL done_state in_ready=%b busy=%b out_valid=%b required 0 1 1",
                 in_ready, busy, out_valid);
      end
      if (h < hold) tick();
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL handshake out_valid=%b in_ready=%b busy=%b required 0 1 0",
               out_valid, in_ready, busy);
    end
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    checks++;
    if ({in_ready, busy, out_valid, out_diff, out_borrow, out_zero, out_parity, out_sign, out_overflow}
        !== {1'b1, 1'b0, 1'b0, {W{1'b0}}, 5'b0}) begin
      errors++;
      $display("FAIL reset_state rdy=%b busy=%b ov=%b diff=%h flags=%b%b%b%b%b required 1 0 0 0000 00000",
               in_ready, busy, out_valid, out_diff, out_borrow, out_zero, out_parity, out_sign, out_overflow);
    end
  endtask

  task automatic test_vectors();
    run_op(16'h1234, 16'h0234, 0, 1'b0);
    run_op(16'h0000, 16'h0001, 0, 1'b0);
    run_op(16'h8000, 16'h0001, 0, 1'b0);
    run_op(16'hFFFF, 16'h7FFF, 0, 1'b0);
  endtask

  task automatic test_backpressure();
    run_op(16'hA5A5, 16'hA5A5, 3, 1'b0);
  endtask

  task automatic test_ignore_in_valid();
    run_op(16'h4321, 16'hC0DE, 1, 1'b1);
  endtask

  task automatic test_random();
    for (int i = 0; i < 8; i++)
      run_op(16'($urandom), 16'($urandom), int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
  endtask

  task automatic test_flush();
    bit seen;
    in_a = 16'h1111; in_b = 16'h2222; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    checks++;
    if (busy !== 1'b0 || in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_idle busy=%b in_ready=%b out_valid=%b required 0 1 0", busy, in_ready, out_valid);
    end
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (out_valid) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL flush_drop out_valid_seen=%b required 0", seen);
    end
    flush = 1'b1; in_valid = 1'b1; in_a = 16'h0F0F; in_b = 16'h0101;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    checks++;
    if (busy !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL flush_priority busy=%b in_ready=%b required 0 1", busy, in_ready);
    end
    run_op(16'h7FFF, 16'hFFFF, 0, 1'b0);
  endtask

  task automatic test_reset_mid_run();
    in_a = 16'hBEEF; in_b = 16'h1234; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    #2 rst_n = 1'b0;
    #1;
    test_reset();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_release in_ready=%b busy=%b out_valid=%b required 1 0 0", in_ready, busy, out_valid);
    end
    run_op(16'h0100, 16'h0001, 0, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
    in_a = '0; in_b = '0;
    #12;
    test_reset();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    test_vectors();
    test_backpressure();
    test_ignore_in_valid();
    test_flush();
    test_reset_mid_run();
    test_random();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain left=%0d required 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sub_seq_ctrl.md
SUB_SEQ_CTRL -- requirements
Module: sub_seq_ctrl

Interface
REQ-001 SHALL have parameter NIBBLES, default 4, number of 4-bit slices per operand (W = 4*NIBBLES).
REQ-002 SHALL have port clk, input, 1, sole clock, rising-edge.
REQ-003 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port in_valid, input, 1, operand pair offered.
REQ-005 SHALL have port in_ready, output, 1, block can accept operands.
REQ-006 SHALL have ports in_a and in_b, input, W each, minuend and subtrahend (two's complement).
REQ-007 SHALL have port flush, input, 1, synchronous abort of any operation in progress.
REQ-008 SHALL have port out_valid, output, 1, result available.
REQ-009 SHALL have port out_ready, input, 1, consumer accepts result.
REQ-010 SHALL have port out_diff, output, W, difference a-b.
REQ-011 SHALL have ports out_borrow, out_zero, out_parity, out_sign, out_overflow, output, 1 each, result flags.
REQ-012 SHALL have port busy, output, 1, high whenever state is not IDLE.

Function
REQ-013 SHALL implement FSM states IDLE, RUN, DONE; in_ready=1 only in IDLE; out_valid=1 only in DONE.
REQ-014 IDLE->RUN on in_valid&in_ready; operands latched, nibble index cleared to 0, borrow register cleared to 0.
REQ-015 In RUN, each cycle SHALL pass nibble[idx] of a and b plus the borrow register through one slice computing a-b-bin; store the 4-bit difference at nibble idx; update borrow; increment idx.
REQ-016 RUN->DONE on the cycle processing idx=NIBBLES-1; out_valid rises exactly NIBBLES cycles after the accepting edge.
REQ-017 DONE->IDLE on out_valid&out_ready; outputs and flags SHALL remain stable while out_ready=0.
REQ-018 out_borrow = final borrow (unsigned a<b); out_zero = (diff==0); out_parity = XOR of all diff bits; out_sign = diff[W-1]; out_overflow = (a[W-1]^b[W-1]) & (a[W-1]^diff[W-1]).
REQ-019 Flags SHALL be computed from the full W-bit diff, not per nibble.
REQ-020 flush=1 in any state SHALL force IDLE next edge, dropping in-flight and pending results; flush takes priority over in_valid in the same cycle.
REQ-021 in_valid in RUN or DONE SHALL be ignored (no acceptance, no corruption).
REQ-022 Same-cycle DONE completion and new in_valid SHALL NOT overlap: new operands are accepted only the cycle after return to IDLE.

Reset
REQ-023 rst_n low SHALL immediately force IDLE, in_ready=1, busy=0, out_valid=0, out_diff=0, all flags 0, idx=0, borrow=0, including mid-RUN.

Configuration
REQ-024 With SUB_SEQ_SAT_EN defined, when overflow=1 out_diff SHALL saturate: a[W-1]=0 -> 0x7F..F, a[W-1]=1 -> 0x80..0; out_overflow still reports 1; out_zero/out_parity/out_sign SHALL reflect the saturated value.
REQ-025 Without SUB_SEQ_SAT_EN, out_diff SHALL be the wrapped W-bit difference.

Structure
REQ-026 Shared package SHALL hold the FSM state typedef (IDLE/RUN/DONE) and the slice width constant (4).
REQ-027 One sub-module sub_nibble_slice SHALL implement the 4-bit a-b-bin slice from the existing Feynman (inversion) and Peres (sum/carry) gate cells, outputting diff[3:0] and bout.

Verification
REQ-028 NIBBLES=4, a=0x1234, b=0x0234 -> out_valid 4 cycles after accept, diff=0x1000, borrow=0, zero=0, parity=1, overflow=0.
REQ-029 a=0x0000, b=0x0001 -> diff=0xFFFF, borrow=1, sign=1, parity=0, overflow=0.
REQ-030 a=0x8000, b=0x0001 -> overflow=1; diff=0x7FFF without SUB_SEQ_SAT_EN, diff=0x8000 with it.
REQ-031 a=b=0xA5A5, out_ready held 0 for 3 cycles -> diff=0x0000, zero=1 stable throughout, in_ready=0 until handshake, then IDLE.
REQ-032 flush at second RUN cycle -> IDLE next edge, out_valid never asserts; following op a=0x7FFF, b=0xFFFF -> diff=0x8000 (wrap) or 0x7FFF (sat), overflow=1.
REQ-033 rst_n pulsed low mid-RUN -> all outputs at reset values immediately, in_ready=1 after release.
